lif_scheduler: RTL and testbench

Time-multiplexed controller that shares one leaky integrate-and-fire update datapath among `N_NEURONS` neurons. On each `step` pulse it snapshots the synapse inputs and configuration, then sequences through every neuron once, one neuron per clock. For each neuron it integrates, compares against threshold, fires and resets, and applies leak. The block sits between the spike-input fabric and the downstream axon/spike consumers, and it owns the membrane-voltage state for all neurons.

---
 rtl/lif_scheduler_if.sv | 32 +++
 rtl/lif_scheduler.sv | 130 +++++++++++++
 tb/tb_lif_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lif_scheduler_if.sv
// lif_scheduler_if
//   Bundles the timestep handshake, configuration and result signals of the
//   LIF scheduler so the scheduler and its client connect through one port.
//   master: client side (drives step/syn/weight/threshold/tau, observes results)
//   slave : scheduler side (observes inputs, drives busy/done/spikes/v_*)
interface lif_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int W         = 8,
  parameter int IDX_W     = $clog2(N_NEURONS)
);
  logic                 step;
  logic [N_NEURONS-1:0] syn;
  logic [W-1:0]         weight;
  logic [W-1:0]         threshold;
  logic [W-1:0]         tau;
  logic                 busy;
  logic                 done;
  logic [N_NEURONS-1:0] spikes;
  logic                 v_valid;
  logic [IDX_W-1:0]     v_idx;
  logic [W-1:0]         v_out;

  modport master (
    output step, syn, weight, threshold, tau,
    input  busy, done, spikes, v_valid, v_idx, v_out
  );

  modport slave (
    input  step, syn, weight, threshold, tau,
    output busy, done, spikes, v_valid, v_idx, v_out
  );
endinterface

// File: rtl/lif_scheduler.sv
// lif_scheduler
//   Shares one leaky integrate-and-fire update datapath among N_NEURONS
//   neurons. A step accepted in IDLE snapshots syn/weight/threshold/tau, then
//   one neuron is updated per clock (integrate, fire/reset, leak). The block
//   owns the membrane voltages of all neurons.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - lif_scheduler_if.slave: step, syn, weight, threshold, tau in;
//          busy, done, spikes, v_valid, v_idx, v_out out
module lif_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int W         = 8,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input logic             clk,
  input logic             rst,
  lif_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx;
  logic [W-1:0]         v_mem [N_NEURONS];
  logic [N_NEURONS-1:0] syn_l;
  logic [W-1:0]         weight_l, threshold_l, tau_l;
  logic [N_NEURONS-1:0] acc, acc_next;
  logic [N_NEURONS-1:0] spikes_r;
  logic                 done_r, v_valid_r;
  logic [IDX_W-1:0]     v_idx_r;
  logic [W-1:0]         v_out_r;

  logic [W:0]           sum_wide;
  logic [W-1:0]         sum_sat, v_new;
  logic                 fire;
  logic                 last;

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.step) state_next = RUN;
      RUN:     if (last)     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One extra carry bit catches overflow so the integrated value clamps at
  // all-ones; leak is only applied when it cannot underflow.
  always_comb begin
    sum_wide = {1'b0, v_mem[idx]} + {1'b0, (syn_l[idx] ? weight_l : {W{1'b0}})};
    sum_sat  = sum_wide[W] ? {W{1'b1}} : sum_wide[W-1:0];
    fire     = (sum_sat >= threshold_l);
    if (fire)                 v_new = '0;
    else if (sum_sat > tau_l) v_new = sum_sat - tau_l;
    else                      v_new = '0;
    acc_next      = acc;
    acc_next[idx] = acc[idx] | fire;
  end

  // spikes is loaded from acc_next so the last neuron's fire is included on
  // the same edge that raises done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      syn_l       <= '0;
      weight_l    <= '0;
      threshold_l <= '0;
      tau_l       <= '0;
      acc         <= '0;
      spikes_r    <= '0;
      done_r      <= 1'b0;
      v_valid_r   <= 1'b0;
      v_idx_r     <= '0;
      v_out_r     <= '0;
      for (int i = 0; i < N_NEURONS; i++) v_mem[i] <= '0;
    end else begin
      done_r    <= 1'b0;
      v_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.step) begin
            syn_l       <= bus.syn;
            weight_l    <= bus.weight;
            threshold_l <= bus.threshold;
            tau_l       <= bus.tau;
            idx         <= '0;
            acc         <= '0;
          end
        end
        RUN: begin
          v_mem[idx] <= v_new;
          acc        <= acc_next;
          v_valid_r  <= 1'b1;
          v_idx_r    <= idx;
          v_out_r    <= v_new;
          if (last) begin
            done_r   <= 1'b1;
            spikes_r <= acc_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_r;
  assign bus.spikes  = spikes_r;
  assign bus.v_valid = v_valid_r;
  assign bus.v_idx   = v_idx_r;
  assign bus.v_out   = v_out_r;

endmodule

// File: tb/tb_lif_scheduler.sv
// tb_lif_scheduler
//   Drives timesteps into lif_scheduler through its interface. Each accepted
//   step pushes the expected per-neuron updates and spike vector (from a small
//   reference model) into queues; a negedge monitor pops and compares them as
//   the DUT reports updates and done pulses. Cycle-by-cycle handshake timing,
//   ignored mid-run inputs, asynchronous mid-run reset and threshold-zero
//   behaviour are also checked.
module tb_lif_scheduler;

  localparam int N = 4;
  localparam int W = 8;
  localparam int VMAX = (1 << W) - 1;

  typedef struct {
    int idx;
    int v;
  } upd_t;

  logic clk;
  logic rst;

  lif_scheduler_if #(.N_NEURONS(N), .W(W)) bus ();

  lif_scheduler #(.N_NEURONS(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  upd_t         exp_q[$];
  logic [N-1:0] spk_q[$];
  logic [N-1:0] exp_spikes;
  int           model_v [N];
  int           n_checks;
  int           n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model: advances model_v by one timestep and queues the results.
  task automatic pushExpected(input logic [N-1:0] s, input int w, input int thr, input int tau);
    logic [N-1:0] sp;
    int           sum;
    upd_t         e;
    sp = '0;
    for (int i = 0; i < N; i++) begin
      sum = model_v[i] + (s[i] ? w : 0);
      if (sum > VMAX) sum = VMAX;
      if (sum >= thr) begin
        model_v[i] = 0;
        sp[i]      = 1'b1;
      end else begin
        model_v[i] = (sum > tau) ? sum - tau : 0;
      end
      e.idx = i;
      e.v   = model_v[i];
      exp_q.push_back(e);
    end
    spk_q.push_back(sp);
  endtask

  task automatic clearModel();
    exp_q.delete();
    spk_q.delete();
    exp_spikes = '0;
    for (int i = 0; i < N; i++) model_v[i] = 0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_spikes", bus.spikes, 0);
    checkOutput("rst_v_valid", bus.v_valid, 0);
    checkOutput("rst_v_idx", bus.v_idx, 0);
    checkOutput("rst_v_out", bus.v_out, 0);
    rst = 1'b1;
  endtask

  // Runs one full timestep with per-cycle handshake checks. With mess set,
  // step is re-pulsed and weight changed to 99 while the timestep is running.
  task automatic applyStimulus(input logic [N-1:0] s, input int w, input int thr,
                               input int tau, input bit mess);
    @(negedge clk);
    bus.syn       = s;
    bus.weight    = W'(w);
    bus.threshold = W'(thr);
    bus.tau       = W'(tau);
    bus.step      = 1'b1;
    pushExpected(s, w, thr, tau);
    @(negedge clk);
    bus.step = 1'b0;
    checkOutput("busy_rise", bus.busy, 1);
    checkOutput("done_early", bus.done, 0);
    checkOutput("valid_early", bus.v_valid, 0);
    for (int j = 1; j <= N; j++) begin
      @(negedge clk);
      checkOutput("v_valid", bus.v_valid, 1);
      checkOutput("v_idx", bus.v_idx, j - 1);
      checkOutput("busy_run", bus.busy, 1);
      checkOutput("done_pulse", bus.done, (j == N) ? 1 : 0);
      if (mess && j == 1) begin
        bus.step   = 1'b1;
        bus.weight = 8'd99;
      end
      if (mess && j == N - 1) bus.step = 1'b0;
    end
    @(negedge clk);
    checkOutput("busy_fall", bus.busy, 0);
    checkOutput("done_fall", bus.done, 0);
    checkOutput("valid_fall", bus.v_valid, 0);
    @(negedge clk);
    checkOutput("busy_idle", bus.busy, 0);
    checkOutput("done_idle", bus.done, 0);
    checkOutput("sb_drain", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: compares reported updates and spike vectors.
  always @(negedge clk) begin
    upd_t e;
    if (bus.v_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_update", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_v_idx", bus.v_idx, e.idx);
        checkOutput("sb_v_out", bus.v_out, e.v);
      end
    end
    if (bus.done === 1'b1) begin
      if (spk_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_spikes = spk_q.pop_front();
        checkOutput("sb_spikes", bus.spikes, exp_spikes);
      end
    end else begin
      checkOutput("spikes_hold", bus.spikes, exp_spikes);
    end
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.step      = 1'b0;
    bus.syn       = '0;
    bus.weight    = '0;
    bus.threshold = '0;
    bus.tau       = '0;
    clearModel();
    #2;
    $display("[TB] reset");
    doReset();

    $display("[TB] integrate-and-fire");
    for (int k = 0; k < 3; k++) applyStimulus(4'b0001, 10, 30, 2, 1'b0);
    checkOutput("if_no_spike", bus.spikes, 0);
    applyStimulus(4'b0001, 10, 30, 2, 1'b0);
    checkOutput("if_spikes", bus.spikes, 4'b0001);

    $display("[TB] saturation");
    applyStimulus(4'b1111, 200, 255, 0, 1'b0);
    checkOutput("sat_high", bus.v_out, 200);
    applyStimulus(4'b1111, 200, 255, 0, 1'b0);
    checkOutput("sat_fire", bus.spikes, 4'b1111);
    applyStimulus(4'b1111, 3, 255, 0, 1'b0);
    applyStimulus(4'b1111, 0, 255, 5, 1'b0);
    checkOutput("sat_floor", bus.v_out, 0);

    $display("[TB] cycle accuracy and ignored inputs");
    applyStimulus(4'b0010, 10, 30, 2, 1'b1);
    checkOutput("ign_v1", model_v[1], 8);

    $display("[TB] reset mid-run");
    @(negedge clk);
    bus.syn       = 4'b1111;
    bus.weight    = 8'd50;
    bus.threshold = 8'd200;
    bus.tau       = 8'd0;
    bus.step      = 1'b1;
    pushExpected(4'b1111, 50, 200, 0);
    @(negedge clk);
    bus.step = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    clearModel();
    #1;
    checkOutput("mid_rst_busy", bus.busy, 0);
    checkOutput("mid_rst_done", bus.done, 0);
    checkOutput("mid_rst_valid", bus.v_valid, 0);
    checkOutput("mid_rst_v_idx", bus.v_idx, 0);
    checkOutput("mid_rst_v_out", bus.v_out, 0);
    checkOutput("mid_rst_spikes", bus.spikes, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("mid_rst_no_done", bus.done, 0);
    end
    rst = 1'b1;
    applyStimulus(4'b1111, 5, 100, 1, 1'b0);
    checkOutput("post_rst_v", bus.v_out, 4);

    $display("[TB] threshold zero");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0000, 0, 0, 3, 1'b0);
      checkOutput("thr0_spikes", bus.spikes, 4'b1111);
      checkOutput("thr0_v", bus.v_out, 0);
    end

    $display("[TB] random timesteps");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(N'($urandom_range(0, 15)), $urandom_range(0, 120),
                    $urandom_range(20, 255), $urandom_range(0, 20), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
